// File: rtl/nibble_serial_pkg.sv
// nibble_serial_pkg
//   Shared definitions for the nibble-serial adder: FSM state encoding and
//   the width of the single adder slice.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_add4.sv
// nibble_add4
//   Combinational 4-bit ripple-carry slice.
//   Ports:
//     a, b     in  4  nibble operands
//     cin      in  1  carry into bit 0
//     sum      out 4  nibble sum
//     carry    out 1  carry out of bit 3
//     msb_cin  out 1  carry into bit 3 (only when NIBBLE_SERIAL_ADDER_OVF_EN
//                     is defined; used for signed-overflow detection)
module nibble_add4
    import nibble_serial_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                carry
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic                msb_cin
`endif
);

    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign carry = c[NIBBLE_W];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign msb_cin = c[NIBBLE_W-1];
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two WIDTH-bit operands one nibble per clock (LSB nibble first)
//   through a single 4-bit slice with a registered inter-nibble carry.
//   {cout,sum} = a + b + cin after NIBBLES cycles.
//   Ports:
//     clk, rst                   clock, async active-high reset
//     start_valid/start_ready    operand handshake (ready only in IDLE)
//     a, b, cin                  operands, captured on acceptance
//     res_valid/res_ready        result handshake
//     sum, cout                  result, stable while res_valid
//     busy                       high in RUN and DONE
//     ovf                        signed overflow, present only when
//                                NIBBLE_SERIAL_ADDER_OVF_EN is defined
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_carry;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
    logic slice_msb_cin;
`endif

    // Operands shift right each RUN cycle, so the slice always sees the
    // low nibble and needs no index mux on its inputs.
    nibble_add4 u_slice (
        .a       (a_q[NIBBLE_W-1:0]),
        .b       (b_q[NIBBLE_W-1:0]),
        .cin     (carry_q),
        .sum     (slice_sum),
        .carry   (slice_carry)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .msb_cin (slice_msb_cin)
`endif
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = slice_sum;
                carry_d = slice_carry;
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_carry;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                    ovf_d   = slice_msb_cin ^ slice_carry;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign ovf         = ovf_q;
`endif

endmodule
